// File: rtl/ufp_mul_arb_pkg.sv
// Shared types and helpers for the fixed-point multiplier arbiter: tag sizing,
// one-hot tag decode and the round-robin first-set search.
package ufp_mul_arb_pkg;

  localparam int unsigned MAX_N     = 8;
  localparam int unsigned MAX_TAG_W = 3;

  function automatic int unsigned tag_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [MAX_N-1:0] onehot_tag(input logic [MAX_TAG_W-1:0] tag);
    return MAX_N'(1) << tag;
  endfunction

  // First set bit of req at or above ptr, wrapping modulo n; returns ptr if none set.
  function automatic int unsigned rr_first(input logic [MAX_N-1:0]     req,
                                           input logic [MAX_TAG_W-1:0] ptr,
                                           input int unsigned          n);
    int unsigned idx;
    int unsigned pos;
    logic        found;
    idx   = 32'(ptr);
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_N; k++) begin
      pos = 32'(ptr) + k;
      if (pos >= n) pos = pos - n;
      if (!found && (k < n) && req[pos[MAX_TAG_W-1:0]]) begin
        idx   = pos;
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first valid requester at or above the
// pointer; the pointer moves past the winner after each grant.
module rr_arbiter
  import ufp_mul_arb_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [N-1:0]            i_req,
  input  logic                    i_advance,
  output logic [N-1:0]            o_grant,
  output logic [tag_width(N)-1:0] o_grant_idx
);

  localparam int unsigned TAG_W = tag_width(N);

  logic [TAG_W-1:0] r_ptr;
  logic             w_any;

  assign w_any       = |i_req;
  assign o_grant_idx = TAG_W'(rr_first(MAX_N'(i_req), MAX_TAG_W'(r_ptr), N));
  assign o_grant     = w_any ? N'(onehot_tag(MAX_TAG_W'(o_grant_idx))) : '0;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr <= '0;
    end else if (i_advance && w_any) begin
      r_ptr <= (o_grant_idx == TAG_W'(N - 1)) ? '0 : o_grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/ufp_mul.sv
// Unsigned IW.QW fixed-point multiply with truncation of the low fraction and
// wrap or saturate of the integer overflow.
module ufp_mul #(
  parameter int unsigned IW   = 8,
  parameter int unsigned QW   = 8,
  parameter int unsigned CLIP = 0
) (
  input  logic [IW+QW-1:0] i_x,
  input  logic [IW+QW-1:0] i_y,
  output logic [IW+QW-1:0] o_val,
  output logic             o_clip
);

  localparam int unsigned W = IW + QW;

  logic [2*W-1:0] w_prod;
  logic           w_unused_frac;

  assign w_prod        = (2*W)'(i_x) * (2*W)'(i_y);
  assign w_unused_frac = ^w_prod[QW-1:0];

  // Any set bit above the IW kept integer bits is an overflow.
  assign o_clip = |w_prod[2*W-1:W+QW];
  assign o_val  = (o_clip && (CLIP != 0)) ? '1 : w_prod[QW +: W];

endmodule

// File: rtl/ufp_mul_arb.sv
// One fixed-point multiplier shared by N requesters: round-robin issue, a
// LAT-deep result pipe, and a tagged one-hot result strobe.
module ufp_mul_arb
  import ufp_mul_arb_pkg::*;
#(
  parameter int unsigned N    = 4,
  parameter int unsigned IW   = 8,
  parameter int unsigned QW   = 8,
  parameter int unsigned LAT  = 2,
  parameter int unsigned CLIP = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          req_valid,
  output logic [N-1:0]          req_ready,
  input  logic [N*(IW+QW)-1:0]  req_x,
  input  logic [N*(IW+QW)-1:0]  req_y,
  output logic [N-1:0]          res_valid,
  output logic [IW+QW-1:0]      res_val,
  output logic                  res_clip,
  output logic                  busy
);

  localparam int unsigned W     = IW + QW;
  localparam int unsigned TAG_W = tag_width(N);

  typedef struct packed {
    logic             vld;
    logic [TAG_W-1:0] tag;
    logic [W-1:0]     val;
    logic             clip;
  } stage_t;

  logic [N-1:0]     w_grant;
  logic [TAG_W-1:0] w_idx;
  logic             w_issue;
  logic [W-1:0]     w_xs [N];
  logic [W-1:0]     w_ys [N];
  logic [W-1:0]     w_mval;
  logic             w_mclip;
  stage_t           w_issue_st;
  stage_t           w_last;
  logic [LAT-1:0]   w_vld;

  rr_arbiter #(
    .N(N)
  ) u_arb (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_req      (req_valid),
    .i_advance  (w_issue),
    .o_grant    (w_grant),
    .o_grant_idx(w_idx)
  );

  assign req_ready = w_grant;
  assign w_issue   = |w_grant;

  for (genvar i = 0; i < N; i++) begin : g_slot
    assign w_xs[i] = req_x[i*W +: W];
    assign w_ys[i] = req_y[i*W +: W];
  end

  ufp_mul #(
    .IW  (IW),
    .QW  (QW),
    .CLIP(CLIP)
  ) u_mul (
    .i_x   (w_xs[w_idx]),
    .i_y   (w_ys[w_idx]),
    .o_val (w_mval),
    .o_clip(w_mclip)
  );

  assign w_issue_st = '{vld: w_issue, tag: w_idx, val: w_mval, clip: w_mclip};

  // Payload only loads behind a valid, so the last stage holds the most
  // recently strobed result through bubbles.
  for (genvar s = 0; s < LAT; s++) begin : g_stage
    stage_t r_st;
    stage_t w_prev;

    if (s == 0) begin : g_first
      assign w_prev = w_issue_st;
    end else begin : g_next
      assign w_prev = g_stage[s-1].r_st;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_st <= '0;
      end else begin
        r_st.vld <= w_prev.vld;
        if (w_prev.vld) begin
          r_st.tag  <= w_prev.tag;
          r_st.val  <= w_prev.val;
          r_st.clip <= w_prev.clip;
        end
      end
    end

    assign w_vld[s] = r_st.vld;
  end

  assign w_last    = g_stage[LAT-1].r_st;
  assign res_valid = w_last.vld ? N'(onehot_tag(MAX_TAG_W'(w_last.tag))) : '0;
  assign res_val   = w_last.val;
  assign res_clip  = w_last.clip;
  assign busy      = |w_vld;

endmodule

// File: tb/tb_ufp_mul_arb.sv
// Scoreboard bench for ufp_mul_arb: wrap and saturate instances share stimulus.
module tb_ufp_mul_arb;

  localparam int N   = 4;
  localparam int IW  = 8;
  localparam int QW  = 8;
  localparam int W   = IW + QW;
  localparam int LAT = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_x = '0;
  logic [N*W-1:0] req_y = '0;
  logic [N-1:0]   req_ready, req_ready_s, res_valid, res_valid_s;
  logic [W-1:0]   res_val, res_val_s;
  logic           res_clip, res_clip_s, busy, busy_s;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int mptr = 0;
  int tag1_cnt = 0;
  bit watch1 = 1'b0;
  logic [W-1:0] hold_val = '0;
  logic [W-1:0] hold_val_s = '0;
  logic         hold_clip = 1'b0;
  int seq[6] = '{0, 1, 2, 3, 0, 1};

  typedef struct {
    int           tag;
    logic [W-1:0] val;
    logic         clip;
    logic [W-1:0] val_sat;
    int           cyc;
  } exp_t;
  exp_t sb[$];

  ufp_mul_arb #(.N(N), .IW(IW), .QW(QW), .LAT(LAT), .CLIP(0)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .res_valid(res_valid), .res_val(res_val),
    .res_clip(res_clip), .busy(busy)
  );

  ufp_mul_arb #(.N(N), .IW(IW), .QW(QW), .LAT(LAT), .CLIP(1)) dut_sat (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_s),
    .req_x(req_x), .req_y(req_y), .res_valid(res_valid_s), .res_val(res_val_s),
    .res_clip(res_clip_s), .busy(busy_s)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int model_grant(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (p + k) % N;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic exp_t model_mul(input int tag, input logic [W-1:0] x,
                                     input logic [W-1:0] y, input int c);
    exp_t e;
    longint unsigned p;
    longint unsigned lim;
    lim       = 64'd1 << W;
    p         = (longint'(x) * longint'(y)) >> QW;
    e.tag     = tag;
    e.clip    = (p >= lim);
    e.val     = W'(p % lim);
    e.val_sat = e.clip ? W'(lim - 1) : e.val;
    e.cyc     = c;
    return e;
  endfunction

  function automatic logic [N*W-1:0] put(input int i, input logic [W-1:0] v);
    logic [N*W-1:0] r;
    r = '0;
    r[i*W +: W] = v;
    return r;
  endfunction

  function automatic logic [N*W-1:0] rand_ops();
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) begin
      r[i*W +: W] = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 4095));
    end
    return r;
  endfunction

  // Called just after a rising edge; returns there one cycle later.
  task automatic step(input logic [N-1:0] v, input logic [N*W-1:0] x,
                      input logic [N*W-1:0] y, output logic [N-1:0] rdy);
    int g;
    logic [N-1:0] er;
    req_valid = v;
    req_x     = x;
    req_y     = y;
    @(negedge clk);
    rdy = req_ready;
    g   = model_grant(v, mptr);
    er  = '0;
    if (g >= 0) er[g] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(er));
    check("req_ready_sat", 32'(req_ready_s), 32'(er));
    if (g >= 0) begin
      sb.push_back(model_mul(g, x[g*W +: W], y[g*W +: W], cyc));
      mptr = (g + 1) % N;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    logic [N-1:0] d;
    step('0, '0, '0, d);
  endtask

  task automatic pulse_reset();
    req_valid  = '0;
    rst        = 1'b1;
    sb.delete();
    mptr       = 0;
    hold_val   = '0;
    hold_val_s = '0;
    hold_clip  = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < LAT + 4 && sb.size() > 0; k++) idle();
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  always @(negedge clk) begin : p_mon
    exp_t e;
    bit exp_busy;
    logic [N-1:0] oh;
    #1;
    exp_busy = (sb.size() > 0) && (sb[0].cyc < cyc);
    check("busy", 32'(busy), 32'(exp_busy));
    check("busy_sat", 32'(busy_s), 32'(exp_busy));
    if (res_valid != '0) begin
      if (res_valid[1] && watch1) tag1_cnt++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: res_valid=0x%0h, expected none (cycle %0d)",
                 res_valid, cyc);
      end else begin
        e  = sb.pop_front();
        oh = '0;
        oh[e.tag] = 1'b1;
        check("res_valid", 32'(res_valid), 32'(oh));
        check("res_valid_sat", 32'(res_valid_s), 32'(oh));
        check("res_val", 32'(res_val), 32'(e.val));
        check("res_clip", 32'(res_clip), 32'(e.clip));
        check("res_val_sat", 32'(res_val_s), 32'(e.val_sat));
        check("res_clip_sat", 32'(res_clip_s), 32'(e.clip));
        check("latency", 32'(cyc), 32'(e.cyc + LAT));
        hold_val   = e.val;
        hold_val_s = e.val_sat;
        hold_clip  = e.clip;
      end
    end else if (sb.size() > 0 && sb[0].cyc + LAT <= cyc) begin
      e  = sb.pop_front();
      oh = '0;
      oh[e.tag] = 1'b1;
      check("res_valid_missing", 32'(res_valid), 32'(oh));
    end else begin
      check("res_valid_sat_idle", 32'(res_valid_s), 32'd0);
      check("res_val_hold", 32'(res_val), 32'(hold_val));
      check("res_clip_hold", 32'(res_clip), 32'(hold_clip));
      check("res_val_sat_hold", 32'(res_val_s), 32'(hold_val_s));
    end
  end

  initial begin
    logic [N-1:0] rdy;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    step('0, '0, '0, rdy);
    check("reset_ready", 32'(rdy), 32'd0);

    // 1.5 x 2.0 from requester 2
    step(4'b0100, put(2, 16'h0180), put(2, 16'h0200), rdy);
    check("t1_ready", 32'(rdy), 32'b0100);
    idle();
    check("t1_res_valid", 32'(res_valid), 32'b0100);
    check("t1_res_val", 32'(res_val), 32'h0300);
    check("t1_res_clip", 32'(res_clip), 32'd0);
    check("t1_busy", 32'(busy), 32'd1);
    drain();

    // Fairness from reset
    pulse_reset();
    for (int k = 0; k < 6; k++) begin
      step(4'hF, rand_ops(), rand_ops(), rdy);
      check("rr_seq", 32'(rdy), 32'(1) << seq[k]);
    end
    drain();

    // Pointer skip: grant 2 leaves ptr=3
    step(4'b0100, rand_ops(), rand_ops(), rdy);
    step(4'b0010, rand_ops(), rand_ops(), rdy);
    check("skip_grant1", 32'(rdy), 32'b0010);
    step(4'b0101, rand_ops(), rand_ops(), rdy);
    check("skip_grant2", 32'(rdy), 32'b0100);
    step(4'b0101, rand_ops(), rand_ops(), rdy);
    check("skip_grant0", 32'(rdy), 32'b0001);
    drain();

    // Overflow 16.0 x 16.0
    step(4'b0001, put(0, 16'h1000), put(0, 16'h1000), rdy);
    idle();
    check("ovf_wrap_val", 32'(res_val), 32'h0000);
    check("ovf_wrap_clip", 32'(res_clip), 32'd1);
    check("ovf_sat_val", 32'(res_val_s), 32'hFFFF);
    check("ovf_sat_clip", 32'(res_clip_s), 32'd1);
    drain();

    // Reset with two operations in flight
    step(4'b0001, rand_ops(), rand_ops(), rdy);
    step(4'b0010, rand_ops(), rand_ops(), rdy);
    pulse_reset();
    repeat (LAT + 2) idle();
    step(4'b1000, rand_ops(), rand_ops(), rdy);
    check("post_rst_grant3", 32'(rdy), 32'b1000);
    step(4'b1001, rand_ops(), rand_ops(), rdy);
    check("post_rst_grant0", 32'(rdy), 32'b0001);
    drain();

    // Requester 1 withdraws before it can win
    pulse_reset();
    watch1 = 1'b1;
    step(4'b0011, rand_ops(), rand_ops(), rdy);
    check("wd_grant0_a", 32'(rdy), 32'b0001);
    step(4'b0001, rand_ops(), rand_ops(), rdy);
    check("wd_grant0_b", 32'(rdy), 32'b0001);
    step(4'b0001, rand_ops(), rand_ops(), rdy);
    drain();
    watch1 = 1'b0;
    check("wd_no_tag1", 32'(tag1_cnt), 32'd0);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      step(N'($urandom_range(0, 15)), rand_ops(), rand_ops(), rdy);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ufp_mul_arb.md
Name: ufp_mul_arb

Overview:
- Shares one unsigned fixed-point multiplier (ufp_mul + output resize) between N requesters, e.g. the ray-tracer shading and intersection units.
- Round-robin arbitration, one issue per cycle, fixed-latency pipelined datapath.
- Results carry a requester tag and return as a one-hot valid with broadcast data.
- No result backpressure: a requester must sink its result in the cycle it is presented.

Parameters:
- N, 4, number of requesters (2..8)
- IW, 8, integer bits of operands and result
- QW, 8, fractional bits of operands and result
- LAT, 2, cycles from issue to result (>=1); all stages are registers after the combinational multiply
- CLIP, 0, overflow policy passed to the multiplier (0 = wrap, 1 = saturate)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- req_valid  in  N  request per requester
- req_ready  out  N  one-hot grant; a handshake completes when req_valid[i] and req_ready[i] are both high
- req_x  in  N*(IW+QW)  operand x per requester; slot i is bits [i*W +: W], W = IW+QW
- req_y  in  N*(IW+QW)  operand y per requester; same packing as req_x
- res_valid  out  N  one-hot result strobe, at most one bit set
- res_val  out  IW+QW  product in the same IW.QW format
- res_clip  out  1  overflow indicator for res_val
- busy  out  1  high while any issued operation is still in the pipeline

Behaviour:
- Reset: on rst high, all of the following clear asynchronously:
  - pipeline valid bits
  - round-robin pointer, which resets to 0
  - res_valid, res_val, res_clip, busy
- Reset mid-operation: in-flight operations are discarded and produce no result.
- req_ready is combinational from req_valid and the pointer.
  - The grant goes to the first requester with req_valid high, searching from ptr upward modulo N.
  - req_ready is all zero when no requester is valid.
  - req_ready is asserted only together with req_valid; it never pre-asserts.
- Pointer update: after granting requester g, ptr <= (g+1) mod N. With no grant, ptr holds.
  - Result: a requester held valid waits at most N-1 grants.
- Issue in cycle t (x/y sampled through the grant mux):
  - Multiply full width: product of IW+IW integer bits and QW+QW fractional bits.
  - Resize to IW.QW: drop the low QW fractional bits by truncation; the high IW bits are wrapped or saturated per CLIP.
  - Result, tag and clip flag enter a LAT-deep register pipe.
  - res_valid[g] is high for exactly one cycle at t+LAT, with res_val and res_clip valid in that same cycle.
- Outputs outside a strobe:
  - res_val and res_clip hold their last value when res_valid is all zero.
  - res_valid drops to 0 on cycles with no completing operation.
- res_clip: high when the integer part of the full-width product exceeds IW bits, in both CLIP modes.
- Throughput: one issue per cycle sustained.
  - Back-to-back grants to the same requester are allowed when it is the only valid one.
  - Results return in issue order.
- busy = OR of pipeline valid bits. It does not include the current-cycle grant.
- Requester-side rules:
  - A requester may drop req_valid at any time before its handshake.
  - Operands are sampled only in the handshake cycle.

Decomposition:
- Package ufp_mul_arb_pkg holds:
  - TAG_W = $clog2(N) (minimum 1)
  - a function that one-hot encodes a tag
  - a function for round-robin first-set search from a pointer
- Sub-module rr_arbiter (N):
  - inputs req[N], advance
  - outputs grant[N], grant_idx
  - owns the pointer register and the clk/rst handling
- Top-level contents:
  - the operand mux
  - the ufp_mul instance (operands and result as ufp_if at IW/QW)
  - the LAT-stage pipe of {valid, tag, val, clip}

Test Plan:
- 1.5 x 2.0, N=4, IW=QW=8, LAT=2.
  - Stimulus: requester 2 sends x=0x0180, y=0x0200 in cycle 5.
  - Required: req_ready=0b0100 in cycle 5; res_valid=0b0100 and res_val=0x0300, res_clip=0 in cycle 7; busy high in cycles 6-7.
- Round-robin fairness.
  - Stimulus: all four requesters held valid from reset.
  - Required: grant sequence 0,1,2,3,0,1; results return in that order, one per cycle, starting LAT cycles after the first grant.
- Pointer skip.
  - Stimulus: ptr=3, only requester 1 valid.
  - Required: grant 1; next pointer 2.
  - Follow-up stimulus: requesters 0 and 2 both valid.
  - Required: grant 2 first, then 0.
- Overflow.
  - Stimulus: x=y=0x1000 (16.0).
  - Required with CLIP=1: res_val=0xFFFF, res_clip=1.
  - Required with CLIP=0: res_val=0x0000, res_clip=1.
- Reset mid-flight.
  - Stimulus: issue from requesters 0 and 1 in consecutive cycles, then pulse rst for one cycle one cycle later.
  - Required: no res_valid strobe afterwards; busy=0 and ptr=0 after reset (next sole request from requester 3 granted, following request from requesters 0 and 3 grants 0).
- Withdrawn request.
  - Stimulus: requester 1 raises valid for one cycle while requester 0 holds the grant, then drops.
  - Required: requester 1 is never granted and no result carries tag 1.
